// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - single-pixel WS2812 serial driver; define WS2812_GAMMA_EN for gamma-corrected output
module ws2812_driver #(
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int BIT_CYCLES   = 13,
    parameter int LATCH_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] level_r,
    input  logic [7:0] level_g,
    input  logic [7:0] level_b,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);
    localparam int MAX_A = (T0H_CYCLES > T1H_CYCLES) ? T0H_CYCLES : T1H_CYCLES;
    localparam int MAX_B = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

    function automatic logic [7:0] xfer(input logic [7:0] v);
`ifdef WS2812_GAMMA_EN
        logic [15:0] p;
        p = 16'(v) * 16'(v) + 16'(v);
        return p[15:8];
`else
        return v;
`endif
    endfunction

    state_t      state_q;
    logic [23:0] snap_q;
    logic [23:0] shreg_q;
    logic        first_q;
    logic [4:0]  bit_q;
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] lat_q;
    logic        dout_q;
    logic        busy_q;
    logic        done_q;

    logic [23:0] raw;
    logic [CW:0] cyc_inc;
    logic [CW:0] hi_len;

    assign raw     = {level_g, level_r, level_b};
    assign cyc_inc = {1'b0, cyc_q} + (CW+1)'(1);
    assign hi_len  = shreg_q[23] ? (CW+1)'(T1H_CYCLES) : (CW+1)'(T0H_CYCLES);

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            shreg_q <= '0;
            first_q <= 1'b1;
            bit_q   <= '0;
            cyc_q   <= '0;
            lat_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_q <= 1'b0;
                    done_q <= 1'b0;
                    if (first_q || (raw != snap_q)) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    snap_q  <= raw;
                    shreg_q <= {xfer(level_g), xfer(level_r), xfer(level_b)};
                    first_q <= 1'b0;
                    bit_q   <= 5'd23;
                    cyc_q   <= '0;
                    dout_q  <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    // dout_q is computed one cycle ahead so the pin is a clean register output
                    if (cyc_q == CW'(BIT_CYCLES - 1)) begin
                        cyc_q <= '0;
                        if (bit_q == 5'd0) begin
                            state_q <= LATCH;
                            dout_q  <= 1'b0;
                            lat_q   <= CW'(LATCH_CYCLES - 1);
                            done_q  <= (LATCH_CYCLES == 1);
                        end else begin
                            bit_q   <= bit_q - 5'd1;
                            shreg_q <= {shreg_q[22:0], 1'b0};
                            dout_q  <= 1'b1;
                        end
                    end else begin
                        cyc_q  <= cyc_inc[CW-1:0];
                        dout_q <= (cyc_inc < hi_len);
                    end
                end
                LATCH: begin
                    dout_q <= 1'b0;
                    if (lat_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        lat_q  <= lat_q - CW'(1);
                        done_q <= (lat_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - randomized scoreboard bench for ws2812_driver
module tb_ws2812_driver;
    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int BITC     = 13;
    localparam int LATCH    = 3000;
    localparam int BUSY_LEN = 1 + 24 * BITC + LATCH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lr = 8'h00, lg = 8'h00, lb = 8'h00;
    logic       dout, busy, fd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] last_raw = 24'h0;

    always #5 clk = ~clk;

    ws2812_driver #(
        .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)
    ) dut (
        .clk(clk), .reset(reset), .level_r(lr), .level_g(lg), .level_b(lb),
        .dout(dout), .busy(busy), .frame_done(fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] xf(input int v);
`ifdef WS2812_GAMMA_EN
        return 8'((v * v + v) / 256);
`else
        return 8'(v);
`endif
    endfunction

    function automatic logic [23:0] frame_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {xf(int'(g)), xf(int'(r)), xf(int'(b))};
    endfunction

    task automatic set_levels(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        lr = r; lg = g; lb = b;
        if ({g, r, b} != last_raw) begin
            exp_q.push_back(frame_of(r, g, b));
            last_raw = {g, r, b};
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!fd && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, {31'b0, fd}, 1);
        @(negedge clk);
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        int t = 0;
        logic pd;
        pd = dout;
        while (k < n && t < 2000) begin
            @(negedge clk);
            t++;
            if (dout && !pd) k++;
            pd = dout;
        end
        check("rises_reached", k, n);
    endtask

    // Monitor: decodes the line back into 24-bit words and pops the scoreboard
    int m_hi = 0, m_lo = 0, m_bits = 0, m_badw = 0, m_badp = 0, m_busy_len = 0, m_idle_hi = 0;
    logic [23:0] m_word = 24'h0;
    logic p_dout = 1'b0, p_busy = 1'b0, p_fd = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_bits = 0; m_badw = 0; m_badp = 0; m_busy_len = 0;
            p_dout = 1'b0; p_busy = 1'b0; p_fd = 1'b0;
        end else begin
            if (p_fd) begin
                check("frame_done_width", {31'b0, fd}, 0);
                check("busy_after_done", {31'b0, busy}, 0);
            end
            if (fd) check("busy_during_done", {31'b0, busy}, 1);
            if (dout && !busy) m_idle_hi++;
            if (busy) m_busy_len++;
            if (p_busy && !busy) begin
                check("busy_length", m_busy_len, BUSY_LEN);
                m_busy_len = 0;
            end
            if (dout) begin
                if (!p_dout) begin
                    if (m_bits > 0 && m_hi + m_lo != BITC) m_badp++;
                    m_hi = 0;
                    m_lo = 0;
                end
                m_hi++;
            end else begin
                if (p_dout) begin
                    m_word = {m_word[22:0], (m_hi == T1H)};
                    if (m_hi != T0H && m_hi != T1H) m_badw++;
                    m_bits++;
                    if (m_bits == 24) begin
                        check("expected_available", {31'b0, exp_q.size() != 0}, 1);
                        if (exp_q.size() != 0) check("frame_data", m_word, exp_q.pop_front());
                        check("bad_high_widths", m_badw, 0);
                        check("bad_bit_periods", m_badp, 0);
                        m_bits = 0; m_badw = 0; m_badp = 0;
                    end
                end
                m_lo++;
            end
            p_dout = dout; p_busy = busy; p_fd = fd;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] r, g, b;
        repeat (3) @(negedge clk);
        check("reset_dout", {31'b0, dout}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, fd}, 0);

        // First frame after reset even with all-zero levels
        exp_q.push_back(frame_of(8'h00, 8'h00, 8'h00));
        last_raw = 24'h0;
        reset = 1'b0;
        @(negedge clk);
        check("load_busy", {31'b0, busy}, 1);
        check("load_dout", {31'b0, dout}, 0);
        @(negedge clk);
        check("first_send_dout", {31'b0, dout}, 1);
        wait_done("zero_frame");

        set_levels(8'h00, 8'h80, 8'h01);
        wait_done("g80_b01");

        set_levels(8'd128, 8'd128, 8'd128);
        wait_done("mid_grey");

        // Change during SEND: current frame unaffected, follow-up frame right after
        set_levels(8'h10, 8'h33, 8'h55);
        wait_rises(6);
        set_levels(8'h20, 8'h33, 8'h55);
        n = 0;
        while (!fd && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("first_of_pair_done", {31'b0, fd}, 1);
        n = 0;
        while (!dout && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("restart_gap", n, 3);
        wait_done("second_of_pair");

        // Reset mid-SEND aborts the frame
        set_levels(8'h12, 8'h34, 8'h56);
        wait_rises(11);
        reset = 1'b1;
        @(negedge clk);
        check("abort_dout", {31'b0, dout}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(frame_of(lr, lg, lb));
        reset = 1'b0;
        wait_done("after_abort");

        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            if ({g, r, b} == last_raw) r = r ^ 8'h01;
            set_levels(r, g, b);
            wait_done("random");
        end

        // Stable inputs: nothing more should be sent
        n = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (dout || busy || fd) n++;
        end
        check("idle_activity", n, 0);
        check("queue_drained", exp_q.size(), 0);
        check("dout_outside_busy", m_idle_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
